// File: rtl/instr_fetch_pkg.sv
// Shared widths and FSM encoding for the instruction fetch unit.
package instr_fetch_pkg;
  localparam int unsigned INSTR_W     = 19;
  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned OFFS_W      = 8;
  localparam int unsigned STACK_DEPTH = 8;
  localparam int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W       = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2
  } state_t;
endpackage

// File: rtl/instr_fetch_return_stack.sv
// Subroutine return-address stack; push on full and pop on empty are ignored.
module return_stack
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] dataIn,
  output logic [ADDR_W-1:0] dataOut,
  output logic              full,
  output logic              empty
);
  logic [ADDR_W-1:0]  mem [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth;
  logic [IDX_W-1:0]   wrIdx;
  logic [IDX_W-1:0]   topIdx;

  assign full    = (depth == DEPTH_W'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign wrIdx   = IDX_W'(depth);
  assign topIdx  = IDX_W'(depth - DEPTH_W'(1));
  assign dataOut = mem[topIdx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth <= depth - DEPTH_W'(1);
    end
  end

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wrIdx] <= dataIn;
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, instruction register, fetch/decode FSM and call/return handling.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic               enablePC,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jumpAddr,
  input  logic               branchTaken,
  input  logic [OFFS_W-1:0]  branchOffset,
  input  logic               call,
  input  logic               ret,
  output logic [ADDR_W-1:0]  pcOut,
  output logic [INSTR_W-1:0] allBits,
  output logic               valid,
  output logic               stackOverflow,
  output logic               stackUnderflow
);
  state_t             state, stateNext;
  logic [ADDR_W-1:0]  pc, pcNext, pcPlus1, branchTarget, stackTop;
  logic               push, pop, full, empty;
  logic               load, advance, setOvf, setUnf;

  assign pcOut        = pc;
  assign pcPlus1      = pc + ADDR_W'(1);
  assign branchTarget = pc + {{(ADDR_W - OFFS_W){branchOffset[OFFS_W-1]}}, branchOffset};

  return_stack uStack (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .dataIn  (pcPlus1),
    .dataOut (stackTop),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    push      = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    setOvf    = 1'b0;
    setUnf    = 1'b0;
    case (state)
      S_IDLE:  stateNext = S_FETCH;
      S_FETCH: begin
        load      = 1'b1;
        stateNext = S_DECODE;
      end
      S_DECODE: begin
        if (enablePC) begin
          advance   = 1'b1;
          stateNext = S_FETCH;
          // ret outranks call, so a simultaneous call never touches the stack.
          if (ret) begin
            if (empty) begin
              pcNext = pcPlus1;
              setUnf = 1'b1;
            end else begin
              pcNext = stackTop;
              pop    = 1'b1;
            end
          end else if (call) begin
            pcNext = jumpAddr;
            if (full) setOvf = 1'b1;
            else      push   = 1'b1;
          end else if (jump) begin
            pcNext = jumpAddr;
          end else if (branchTaken) begin
            pcNext = branchTarget;
          end else begin
            pcNext = pcPlus1;
          end
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      pc             <= '0;
      allBits        <= '0;
      valid          <= 1'b0;
      stackOverflow  <= 1'b0;
      stackUnderflow <= 1'b0;
    end else begin
      state          <= stateNext;
      stackOverflow  <= stackOverflow | setOvf;
      stackUnderflow <= stackUnderflow | setUnf;
      if (load) begin
        allBits <= instrIn;
        valid   <= 1'b1;
      end
      if (advance) begin
        pc    <= pcNext;
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: driver predicts each fetch, monitor checks it on valid.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [18:0] instrIn;
  logic        enablePC = 1'b0, jump = 1'b0, branchTaken = 1'b0, call = 1'b0, ret = 1'b0;
  logic [11:0] jumpAddr = '0;
  logic [7:0]  branchOffset = '0;
  logic [11:0] pcOut;
  logic [18:0] allBits;
  logic        valid, stackOverflow, stackUnderflow;

  logic [18:0] imem [4096];
  assign instrIn = imem[pcOut];

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .instrIn        (instrIn),
    .enablePC       (enablePC),
    .jump           (jump),
    .jumpAddr       (jumpAddr),
    .branchTaken    (branchTaken),
    .branchOffset   (branchOffset),
    .call           (call),
    .ret            (ret),
    .pcOut          (pcOut),
    .allBits        (allBits),
    .valid          (valid),
    .stackOverflow  (stackOverflow),
    .stackUnderflow (stackUnderflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc;
    logic [18:0] instr;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        expQ [$];
  int          total = 0;
  int          bad = 0;

  logic [11:0] mpc;
  logic [11:0] mstack [$];
  logic        movf, munf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic junkControls();
    jump = 1'($urandom); call = 1'($urandom); ret = 1'($urandom);
    branchTaken = 1'($urandom); jumpAddr = 12'($urandom); branchOffset = 8'($urandom);
  endtask

  task automatic modelApply(input logic r, input logic c, input logic j, input logic b,
                            input logic [7:0] off, input logic [11:0] ja);
    int t;
    if (r) begin
      if (mstack.size() > 0) mpc = mstack.pop_back();
      else begin mpc = 12'((int'(mpc) + 1) % 4096); munf = 1'b1; end
    end else if (c) begin
      if (mstack.size() < 8) mstack.push_back(12'((int'(mpc) + 1) % 4096));
      else movf = 1'b1;
      mpc = ja;
    end else if (j) begin
      mpc = ja;
    end else if (b) begin
      t   = int'(mpc) + int'($signed(off));
      mpc = 12'((t + 4096) % 4096);
    end else begin
      mpc = 12'((int'(mpc) + 1) % 4096);
    end
  endtask

  task automatic waitValid();
    int n = 0;
    while (!valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!valid) chk("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic doStep(input logic r, input logic c, input logic j, input logic b,
                        input logic [7:0] off, input logic [11:0] ja);
    waitValid();
    repeat ($urandom_range(0, 2)) begin
      junkControls();
      enablePC = 1'b0;
      @(posedge clk); #1;
    end
    ret = r; call = c; jump = j; branchTaken = b; branchOffset = off; jumpAddr = ja;
    enablePC = 1'b1;
    @(posedge clk); #1;
    enablePC = 1'b0;
    junkControls();
    modelApply(r, c, j, b, off, ja);
    expQ.push_back('{pc: mpc, instr: imem[mpc], ovf: movf, unf: munf});
  endtask

  task automatic releaseReset();
    rst = 1'b1;
    expQ.push_back('{pc: 12'h000, instr: imem[0], ovf: 1'b0, unf: 1'b0});
    @(posedge clk); #1;
    chk("latency_valid_c1", 32'(valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_valid_c2", 32'(valid), 32'd1);
    chk("latency_allBits", 32'(allBits), 32'(imem[0]));
  endtask

  task automatic modelReset();
    expQ.delete();
    mstack.delete();
    mpc = '0; movf = 1'b0; munf = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    logic prevValid;
    exp_t e;
    if (rst && valid && !prevValid) begin
      if (expQ.size() == 0) begin
        chk("unexpected_fetch", 32'(pcOut), 32'hFFFFFFFF);
      end else begin
        e = expQ.pop_front();
        chk("fetch_pc", 32'(pcOut), 32'(e.pc));
        chk("fetch_instr", 32'(allBits), 32'(e.instr));
        chk("fetch_ovf", 32'(stackOverflow), 32'(e.ovf));
        chk("fetch_unf", 32'(stackUnderflow), 32'(e.unf));
      end
    end
    prevValid = valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) imem[i] = 19'($urandom);
    imem[0] = 19'b0000010010101100000;
    modelReset();
    #1;
    chk("reset_pc", 32'(pcOut), 32'h0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_allBits", 32'(allBits), 32'd0);
    chk("reset_ovf", 32'(stackOverflow), 32'd0);
    chk("reset_unf", 32'(stackUnderflow), 32'd0);
    @(posedge clk); #1;
    releaseReset();

    doStep(0, 0, 0, 0, 8'h00, 12'h000);
    doStep(0, 0, 0, 0, 8'h00, 12'h000);
    doStep(0, 0, 1, 0, 8'h00, 12'hFFF);
    doStep(0, 0, 0, 0, 8'h00, 12'h000);
    doStep(0, 0, 1, 0, 8'h00, 12'd10);
    doStep(0, 0, 0, 1, 8'hFB, 12'h000);
    doStep(0, 0, 1, 0, 8'h00, 12'hFF0);
    doStep(0, 0, 0, 1, 8'h7F, 12'h000);
    doStep(0, 0, 1, 0, 8'h00, 12'd20);
    doStep(0, 1, 0, 0, 8'h00, 12'd100);
    doStep(1, 0, 0, 0, 8'h00, 12'h000);
    doStep(0, 0, 1, 0, 8'h00, 12'd7);
    doStep(1, 0, 0, 0, 8'h00, 12'h000);
    doStep(0, 1, 0, 0, 8'h00, 12'd300);
    doStep(1, 1, 1, 1, 8'h05, 12'd400);
    doStep(1, 0, 0, 0, 8'h00, 12'h000);
    for (int k = 0; k < 9; k++) doStep(0, 1, 0, 0, 8'h00, 12'(16 * k + 3));

    doStep(0, 0, 1, 0, 8'h00, 12'd50);
    waitValid();
    chk("pre_reset_pc", 32'(pcOut), 32'd50);
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    chk("midreset_pc", 32'(pcOut), 32'h0);
    chk("midreset_valid", 32'(valid), 32'd0);
    chk("midreset_allBits", 32'(allBits), 32'd0);
    chk("midreset_ovf", 32'(stackOverflow), 32'd0);
    chk("midreset_unf", 32'(stackUnderflow), 32'd0);
    @(posedge clk); #1;
    releaseReset();

    for (int k = 0; k < 300; k++) begin
      doStep(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
             8'($urandom), 12'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
